// File: rtl/imem_fetch_ctrl_if.sv
// Fetch-side bundle: ROM address/data, redirect request, decode handshake and fault flag.
// The fetch controller takes the master modport.
interface imem_fetch_ctrl_if #(
  parameter int unsigned N = 64,
  parameter int unsigned W = 32
) ();
  logic         fetch_en;
  logic [5:0]   imem_addr;
  logic [W-1:0] imem_q;
  logic         redirect_valid;
  logic [N-1:0] redirect_pc;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_instr;
  logic [N-1:0] out_pc;
  logic         fault;

  modport master (
    input  fetch_en, imem_q, redirect_valid, redirect_pc, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, fault
  );

  modport slave (
    output fetch_en, imem_q, redirect_valid, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, fault
  );
endinterface

// File: rtl/imem_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the fetch PC, reads the 64-word ROM, buffers words in a
// small prefetch queue for decode, and handles redirects, pause and sticky address faults.
module imem_fetch_ctrl #(
  parameter int unsigned   N        = 64,
  parameter int unsigned   W        = 32,
  parameter int unsigned   DEPTH    = 2,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input logic               clk,
  input logic               reset,
  imem_fetch_ctrl_if.master bus
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {StIdle, StRun, StFault} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   pc_q, pc_d;
  logic [N-1:0]   pc_mem_q    [DEPTH];
  logic [W-1:0]   instr_mem_q [DEPTH];
  logic [AW-1:0]  rd_ptr_q, wr_ptr_q;
  logic [CW-1:0]  cnt_q;

  logic redirect, pc_legal, full, pop, attempt, push;

  // A redirect in the fault state is dropped entirely, including its flush.
  assign redirect = bus.redirect_valid && (state_q != StFault);
  assign pc_legal = (pc_q[1:0] == 2'b00) && (pc_q[N-1:8] == '0);
  assign full     = (cnt_q == CW'(DEPTH));
  assign pop      = bus.out_valid && bus.out_ready && !redirect;
  assign attempt  = (state_q == StRun) && bus.fetch_en && !redirect;
  assign push     = attempt && pc_legal && (!full || pop);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (bus.fetch_en) state_d = StRun;
      StRun: begin
        if (!bus.fetch_en)               state_d = StIdle;
        else if (attempt && !pc_legal)   state_d = StFault;
      end
      StFault: state_d = StFault;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (redirect)  pc_d = bus.redirect_pc;
    else if (push) pc_d = pc_q + N'(4);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        pc_mem_q[i]    <= '0;
        instr_mem_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      if (redirect) begin
        rd_ptr_q <= '0;
        wr_ptr_q <= '0;
        cnt_q    <= '0;
      end else begin
        if (push) begin
          pc_mem_q[wr_ptr_q]    <= pc_q;
          instr_mem_q[wr_ptr_q] <= bus.imem_q;
          wr_ptr_q              <= wr_ptr_q + AW'(1);
        end
        if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
        cnt_q <= cnt_q + CW'(push) - CW'(pop);
      end
    end
  end

  assign bus.imem_addr = pc_q[7:2];
  assign bus.out_valid = (cnt_q != '0);
  assign bus.out_instr = instr_mem_q[rd_ptr_q];
  assign bus.out_pc    = pc_mem_q[rd_ptr_q];
  assign bus.fault     = (state_q == StFault);

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Directed bench for imem_fetch_ctrl: a scoreboard of expected {pc, instr} pairs is filled as
// stimulus is driven and drained on every completed decode handshake.
module tb_imem_fetch_ctrl;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb[$];

  imem_fetch_ctrl_if #(.N(64), .W(32)) bus ();

  imem_fetch_ctrl #(
    .N(64), .W(32), .DEPTH(2), .RESET_PC(64'h0)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom_word(input logic [5:0] a);
    return 32'hf800_0000 + 32'(a) * 32'h0000_8001;
  endfunction

  assign bus.imem_q = rom_word(bus.imem_addr);

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sb_push(input logic [63:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = rom_word(pc[7:2]);
    sb.push_back(e);
  endtask

  // Compare any handshake completing at the coming edge, then advance one cycle.
  task automatic tick();
    exp_t e;
    if (bus.out_valid && bus.out_ready && !bus.redirect_valid) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected_pop", 64'(bus.out_pc), 64'hffff_ffff_ffff_ffff);
      end else begin
        e = sb.pop_front();
        chk("sb_pc", bus.out_pc, e.pc);
        chk("sb_instr", 64'(bus.out_instr), 64'(e.instr));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic sb_empty(input string tag);
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  task automatic do_reset();
    reset              = 1'b1;
    bus.fetch_en       = 1'b0;
    bus.out_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    sb.delete();
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    do_reset();
    chk("rst_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_instr", 64'(bus.out_instr), 64'd0);
    chk("rst_pc", bus.out_pc, 64'd0);
    chk("rst_fault", 64'(bus.fault), 64'd0);
    chk("rst_addr", 64'(bus.imem_addr), 64'd0);

    // Sequential fetch
    bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
    sb_push(64'h0); sb_push(64'h4); sb_push(64'h8);
    tick();
    chk("seq_idle_valid", 64'(bus.out_valid), 64'd0);
    tick();
    chk("seq_valid_rise", 64'(bus.out_valid), 64'd1);
    chk("seq_first_instr", 64'(bus.out_instr), 64'hf800_0000);
    repeat (3) tick();
    sb_empty("seq_sb_empty");

    // Backpressure
    do_reset();
    bus.fetch_en = 1'b1;
    repeat (3) tick();
    chk("bp_hold_pc_a", bus.out_pc, 64'h0);
    repeat (2) tick();
    chk("bp_valid", 64'(bus.out_valid), 64'd1);
    chk("bp_hold_pc_b", bus.out_pc, 64'h0);
    chk("bp_hold_instr", 64'(bus.out_instr), 64'hf800_0000);
    chk("bp_addr", 64'(bus.imem_addr), 64'd2);
    sb_push(64'h0); sb_push(64'h4); sb_push(64'h8);
    bus.out_ready = 1'b1;
    repeat (3) tick();
    sb_empty("bp_sb_empty");

    // Redirect
    do_reset();
    bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
    sb_push(64'h0);
    repeat (3) tick();
    chk("rd_pc4", bus.out_pc, 64'h4);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h2c;
    tick();
    bus.redirect_valid = 1'b0;
    chk("rd_flush", 64'(bus.out_valid), 64'd0);
    sb_push(64'h2c); sb_push(64'h30);
    tick();
    chk("rd_tgt_valid", 64'(bus.out_valid), 64'd1);
    chk("rd_tgt_pc", bus.out_pc, 64'h2c);
    chk("rd_tgt_instr", 64'(bus.out_instr), 64'(rom_word(6'd11)));
    repeat (2) tick();
    sb_empty("rd_sb_empty");

    // Misaligned redirect target faults; later redirects are ignored
    do_reset();
    bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h102;
    tick();
    bus.redirect_valid = 1'b0;
    chk("flt_not_yet", 64'(bus.fault), 64'd0);
    tick();
    chk("flt_set", 64'(bus.fault), 64'd1);
    chk("flt_no_push", 64'(bus.out_valid), 64'd0);
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h10;
    tick();
    bus.redirect_valid = 1'b0;
    repeat (2) tick();
    chk("flt_sticky", 64'(bus.fault), 64'd1);
    chk("flt_rd_ignored", 64'(bus.imem_addr), 64'd0);
    chk("flt_still_empty", 64'(bus.out_valid), 64'd0);

    // Running off the end of the ROM
    do_reset();
    bus.fetch_en = 1'b1; bus.out_ready = 1'b1;
    tick();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'hf8;
    tick();
    bus.redirect_valid = 1'b0;
    sb_push(64'hf8); sb_push(64'hfc);
    repeat (2) tick();
    chk("wrap_no_fault", 64'(bus.fault), 64'd0);
    tick();
    chk("wrap_fault", 64'(bus.fault), 64'd1);
    chk("wrap_empty", 64'(bus.out_valid), 64'd0);
    tick();
    sb_empty("wrap_sb_empty");

    // Pause drains the queue with the PC frozen
    do_reset();
    bus.fetch_en = 1'b1;
    repeat (3) tick();
    sb_push(64'h0); sb_push(64'h4);
    bus.fetch_en = 1'b0; bus.out_ready = 1'b1;
    repeat (2) tick();
    chk("pause_drained", 64'(bus.out_valid), 64'd0);
    chk("pause_addr", 64'(bus.imem_addr), 64'd2);
    tick();
    chk("pause_addr_held", 64'(bus.imem_addr), 64'd2);
    sb_empty("pause_sb_empty");

    // Redirect against a full queue with out_ready high
    bus.fetch_en = 1'b1; bus.out_ready = 1'b0;
    repeat (3) tick();
    chk("sim_full_pc", bus.out_pc, 64'h8);
    bus.fetch_en = 1'b0; bus.out_ready = 1'b1;
    bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h40;
    tick();
    bus.redirect_valid = 1'b0;
    chk("sim_flushed", 64'(bus.out_valid), 64'd0);
    chk("sim_addr", 64'(bus.imem_addr), 64'h10);
    tick();
    chk("sim_still_empty", 64'(bus.out_valid), 64'd0);

    // Asynchronous reset with a full queue
    do_reset();
    bus.fetch_en = 1'b1;
    repeat (3) tick();
    chk("ar_pre_valid", 64'(bus.out_valid), 64'd1);
    chk("ar_pre_addr", 64'(bus.imem_addr), 64'd2);
    #2;
    reset = 1'b1;
    #1;
    chk("ar_valid", 64'(bus.out_valid), 64'd0);
    chk("ar_fault", 64'(bus.fault), 64'd0);
    chk("ar_addr", 64'(bus.imem_addr), 64'd0);
    chk("ar_pc", bus.out_pc, 64'd0);
    chk("ar_instr", 64'(bus.out_instr), 64'd0);
    reset = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/imem_fetch_ctrl.md
Name: imem_fetch_ctrl

Overview:
- Instruction-fetch sequencer for the 64-word instruction ROM (6-bit word address, 32-bit combinational read).
- Owns the fetch PC and drives the ROM address. Captures instruction words into a small prefetch queue and hands them to decode over a valid/ready handshake.
- Handles branch redirects (queue flush), fetch enable/pause, and sticky faults on misaligned or out-of-range fetch addresses.

Parameters:
- N, 64, width of PC values (fetch PC, redirect target, out_pc)
- W, 32, instruction word width (matches ROM data width)
- DEPTH, 2, prefetch queue entries; power of two, >= 2
- RESET_PC, 0, fetch PC loaded on reset

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  asynchronous, active-high reset
- fetch_en  input  1  1 = fetching allowed; 0 = pause (PC held)
- imem_addr  output  6  ROM word address = fetch_pc[7:2]
- imem_q  input  W  ROM read data for imem_addr, same cycle
- redirect_valid  input  1  branch/jump taken this cycle
- redirect_pc  input  N  byte address of redirect target
- out_valid  output  1  queue head holds a valid instruction
- out_ready  input  1  decode accepts the head this cycle
- out_instr  output  W  instruction at queue head
- out_pc  output  N  byte PC of out_instr
- fault  output  1  sticky: fetch PC misaligned or beyond ROM

Behaviour:
- Reset (async, any state): fetch_pc=RESET_PC, queue empty, state=IDLE, out_valid=0, out_instr=0, out_pc=0, fault=0. imem_addr follows fetch_pc (0 after reset).
- States:
  - IDLE: no pushes. Go to RUN when fetch_en=1.
  - RUN: fetch active. Go to IDLE when fetch_en=0; the PC is held.
  - FAULT: terminal until reset.
- Legal fetch_pc: fetch_pc[1:0]==0 and fetch_pc[N-1:8]==0.
  - In RUN with an illegal fetch_pc: no push, go to FAULT, fault=1 from the next edge.
  - Illegal-PC check has priority over push.
- Push (RUN, legal PC, no redirect, queue not full after this cycle's pop): enqueue {fetch_pc, imem_q}, then fetch_pc <= fetch_pc+4 (N-bit add).
- Full queue with a simultaneous pop: push allowed. Full queue with no pop: fetch_pc held, no push.
- Pop: out_valid && out_ready at the edge. The head advances and the next entry becomes visible the same edge.
- Queue outputs are registered. An entry pushed at edge E is visible with out_valid=1 after E.
- Redirect (IDLE or RUN), highest priority:
  - Flush all entries (out_valid=0 after the edge).
  - fetch_pc <= redirect_pc.
  - No push that cycle.
  - A concurrent pop is discarded; the handshake completes with no effect.
  - Latency: redirect at edge E0 -> target instruction visible (out_valid=1, out_pc=target) after E1, given fetch_en=1.
- Redirect in FAULT: ignored.
- Draining: queued entries remain poppable in FAULT and IDLE.
- Wrap: fetch_pc=0xFC is legal; the increment gives 0x100, which faults on the next attempted push (no silent wrap to address 0).
- Stability: out_instr/out_pc hold while out_valid=1 and out_ready=0.
- Combinational paths: none from out_ready to imem_addr beyond the push decision. imem_addr is purely fetch_pc[7:2].
- Reset during operation: immediate return to the reset values; partial queue discarded.

Test Plan:
- Sequential fetch: ROM word0=32'hf8000000, word1=32'hf8008001, word2=32'hf8010002; reset, then fetch_en=1, out_ready=1 -> out_valid rises 1 cycle after enable; out_pc 0,4,8 on consecutive cycles with those instructions.
- Backpressure: out_ready=0 for 5 cycles -> queue fills to DEPTH=2 (pc 0,4), fetch_pc held at 8, imem_addr=2. Release -> pc 0,4,8 delivered in order with no loss or duplication.
- Redirect: after out_pc=4 appears, pulse redirect_valid with redirect_pc=0x2C -> next cycle out_valid=0; following cycle out_pc=0x2C, out_instr=ROM[11]; pc 0x30 follows.
- Faults: redirect_pc=0x102 -> fault=1 one cycle after the first attempted fetch; no further pushes. Redirect to 0x10 is ignored; fault stays 1 until reset. Separately, running from 0xF8 delivers 0xF8 and 0xFC, then fault=1.
- Pause/simultaneous events: fetch_en=0 mid-stream -> imem_addr frozen, queue drains. Redirect with out_ready=1 and a full queue -> no pop or push observed, queue empty.
- Mid-operation reset: assert reset asynchronously with the queue full -> out_valid, fault and imem_addr go to 0 immediately, without waiting for a clock edge.
